// File: rtl/masked_and_scheduler_if.sv
// Bundle of request, randomness, gadget and response signals for masked_and_scheduler.
// The slave modport is the scheduler's view; master is the surrounding system.
interface masked_and_scheduler_if #(
   parameter int SHARES = 4,
   parameter int RND_W  = 16
);
   logic              req0_valid;
   logic              req0_ready;
   logic [SHARES-1:0] req0_a;
   logic [SHARES-1:0] req0_b;
   logic              req1_valid;
   logic              req1_ready;
   logic [SHARES-1:0] req1_a;
   logic [SHARES-1:0] req1_b;
   logic              rnd_valid;
   logic              rnd_ready;
   logic [RND_W-1:0]  rnd;
   logic [SHARES-1:0] g_a;
   logic [SHARES-1:0] g_b;
   logic [RND_W-1:0]  g_r;
   logic              g_issue;
   logic [SHARES-1:0] g_c;
   logic              rsp_valid;
   logic              rsp_ready;
   logic              rsp_id;
   logic [SHARES-1:0] rsp_c;
   logic              busy;
   logic              rnd_repeat_err;

   modport slave (
      input  req0_valid, req0_a, req0_b,
      output req0_ready,
      input  req1_valid, req1_a, req1_b,
      output req1_ready,
      input  rnd_valid, rnd,
      output rnd_ready,
      output g_a, g_b, g_r, g_issue,
      input  g_c,
      output rsp_valid, rsp_id, rsp_c,
      input  rsp_ready,
      output busy, rnd_repeat_err
   );

   modport master (
      output req0_valid, req0_a, req0_b,
      input  req0_ready,
      output req1_valid, req1_a, req1_b,
      input  req1_ready,
      output rnd_valid, rnd,
      input  rnd_ready,
      input  g_a, g_b, g_r, g_issue,
      output g_c,
      input  rsp_valid, rsp_id, rsp_c,
      output rsp_ready,
      input  busy, rnd_repeat_err
   );
endinterface

// File: rtl/masked_and_scheduler.sv
// Round-robin sequencer sharing one registered masked AND gadget between two requesters.
// Optional macro RND_REPEAT_CHECK_EN flags a consumed randomness word equal to the previous one.
module masked_and_scheduler #(
   parameter int SHARES  = 4,
   parameter int RND_W   = 16,
   parameter int LATENCY = 1
) (
   input logic                 clk,
   input logic                 rst,
   masked_and_scheduler_if.slave bus
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ISSUE = 2'd1;
   localparam logic [1:0] WAIT  = 2'd2;
   localparam logic [1:0] RESP  = 2'd3;

   localparam logic [2:0] LAT = 3'(LATENCY);

   logic [1:0]        state;
   logic              last_grant;
   logic [2:0]        cnt;
   logic [SHARES-1:0] op_a;
   logic [SHARES-1:0] op_b;
   logic [RND_W-1:0]  op_r;
   logic              op_id;
   logic [SHARES-1:0] rsp_c_q;

   logic              grant;
   logic              grant_id;

   // Arbitration is gated by rst so every ready drops the moment reset asserts.
   always_comb begin
      grant    = 1'b0;
      grant_id = 1'b0;
      if (state == IDLE && !rst && bus.rnd_valid) begin
         if (bus.req0_valid && bus.req1_valid) begin
            grant    = 1'b1;
            grant_id = ~last_grant;
         end else if (bus.req0_valid) begin
            grant    = 1'b1;
            grant_id = 1'b0;
         end else if (bus.req1_valid) begin
            grant    = 1'b1;
            grant_id = 1'b1;
         end
      end
   end

   assign bus.req0_ready = grant & ~grant_id;
   assign bus.req1_ready = grant &  grant_id;
   assign bus.rnd_ready  = grant;

   // Operand and randomness registers only hold data during ISSUE, keeping the gadget quiet otherwise.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         cnt        <= 3'd0;
         op_a       <= '0;
         op_b       <= '0;
         op_r       <= '0;
         op_id      <= 1'b0;
         rsp_c_q    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant) begin
                  op_a       <= grant_id ? bus.req1_a : bus.req0_a;
                  op_b       <= grant_id ? bus.req1_b : bus.req0_b;
                  op_r       <= bus.rnd;
                  op_id      <= grant_id;
                  last_grant <= grant_id;
                  state      <= ISSUE;
               end
            end
            ISSUE: begin
               op_a  <= '0;
               op_b  <= '0;
               op_r  <= '0;
               cnt   <= 3'd1;
               state <= WAIT;
            end
            WAIT: begin
               if (cnt == LAT) begin
                  rsp_c_q <= bus.g_c;
                  cnt     <= 3'd0;
                  state   <= RESP;
               end else begin
                  cnt <= cnt + 3'd1;
               end
            end
            RESP: begin
               if (bus.rsp_ready) begin
                  rsp_c_q <= '0;
                  state   <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.g_a       = op_a;
   assign bus.g_b       = op_b;
   assign bus.g_r       = op_r;
   assign bus.g_issue   = (state == ISSUE);
   assign bus.rsp_valid = (state == RESP);
   assign bus.rsp_id    = op_id;
   assign bus.rsp_c     = rsp_c_q;
   assign bus.busy      = (state != IDLE);

`ifdef RND_REPEAT_CHECK_EN
   logic [RND_W-1:0] rnd_last;
   logic             repeat_err;

   // Compare each consumed word with the previous one; the flag stays set until reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rnd_last   <= '0;
         repeat_err <= 1'b0;
      end else if (grant) begin
         rnd_last <= bus.rnd;
         if (bus.rnd == rnd_last) begin
            repeat_err <= 1'b1;
         end
      end
   end

   assign bus.rnd_repeat_err = repeat_err;
`else
   assign bus.rnd_repeat_err = 1'b0;
`endif

endmodule
